can_timing_ctrl: RTL and testbench

//  Owns the bit-timing configuration of can_timing and sequences its changes. Accepts a new

---
 rtl/can_timing_ctrl_pkg.sv | 21 ++
 rtl/can_timing_cfg_check.sv | 22 ++
 rtl/can_timing_ctrl.sv | 174 +++++++++++++++++
 tb/tb_can_timing_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_timing_ctrl_pkg.sv
// Shared types for the CAN bit-timing controller.
// Holds the FSM state enum, the reg2tim bundle and the integration constant.
package can_timing_ctrl_pkg;

  localparam int CAN_INTEG_BITS = 11;

  typedef enum logic [1:0] {
    TC_HOLD,
    TC_INTEG,
    TC_BUS_ON,
    TC_WAIT_IDLE
  } type_tim_ctrl_state_e;

  typedef struct packed {
    logic [5:0] baud_prescaler;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
  } type_reg2tim_s;

endpackage

// File: rtl/can_timing_cfg_check.sv
// Combinational validity check of a bit-timing set.
// Ports: cfg_i (set under test), valid_o (1 = set may be applied).
module can_timing_cfg_check
  import can_timing_ctrl_pkg::*;
(
  input  type_reg2tim_s cfg_i,
  output logic          valid_o
);

  logic t1_ok;
  logic t2_ok;
  logic sjw_ok;
  logic ord_ok;

  assign t1_ok  = (cfg_i.tseg1 != 4'd0);
  assign t2_ok  = (cfg_i.tseg2 != 3'd0);
  assign sjw_ok = ({1'b0, cfg_i.sjw} <= cfg_i.tseg2);
  assign ord_ok = (cfg_i.tseg1 >= {1'b0, cfg_i.tseg2});

  assign valid_o = t1_ok & t2_ok & sjw_ok & ord_ok;

endmodule

// File: rtl/can_timing_ctrl.sv
// Sequences bit-timing changes: validate, defer to idle, hold, re-integrate.
// Ports: cfg req/ack handshake, bus status, sample strobe, reg2tim/tim_rst_n/bus_on out.
module can_timing_ctrl
  import can_timing_ctrl_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter int         INTEG_BITS  = CAN_INTEG_BITS,
  parameter logic [5:0] DEF_PRESC   = 6'd0,
  parameter logic [3:0] DEF_TSEG1   = 4'd5,
  parameter logic [2:0] DEF_TSEG2   = 3'd2,
  parameter logic [1:0] DEF_SJW     = 2'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_req_i,
  input  logic [5:0]    cfg_presc_i,
  input  logic [3:0]    cfg_tseg1_i,
  input  logic [2:0]    cfg_tseg2_i,
  input  logic [1:0]    cfg_sjw_i,
  output logic          cfg_ack_o,
  output logic          cfg_err_o,
  input  logic          rx_idle_i,
  input  logic          tx_busy_i,
  input  logic          sample_point_i,
  input  logic          sampled_bit_i,
  output type_reg2tim_s reg2tim_o,
  output logic          tim_rst_n_o,
  output logic          bus_on_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = $clog2(INTEG_BITS + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] INTEG_LAST = IW'(INTEG_BITS - 1);
  localparam logic [IW-1:0] INTEG_MAX = IW'(INTEG_BITS);

  localparam type_reg2tim_s DEF_CFG = '{
    baud_prescaler: DEF_PRESC,
    tseg1:          DEF_TSEG1,
    tseg2:          DEF_TSEG2,
    sjw:            DEF_SJW
  };

  type_tim_ctrl_state_e state;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] integ_cnt;
  logic          req_seen;
  logic          pend;
  type_reg2tim_s shadow;
  type_reg2tim_s reg2tim_q;
  logic          tim_rst_q;
  logic          bus_on_q;
  logic          ack_q;
  logic          err_q;

  type_reg2tim_s cfg_in;
  logic          cfg_ok;
  logic          accept;

  assign cfg_in = '{
    baud_prescaler: cfg_presc_i,
    tseg1:          cfg_tseg1_i,
    tseg2:          cfg_tseg2_i,
    sjw:            cfg_sjw_i
  };

  can_timing_cfg_check u_chk (
    .cfg_i   (cfg_in),
    .valid_o (cfg_ok)
  );

  // Requests are only taken while the node is running,
  // and only once per rising level of cfg_req_i.
  assign accept = cfg_req_i & ~req_seen &
                  ((state == TC_INTEG) | (state == TC_BUS_ON));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TC_HOLD;
      hold_cnt  <= HOLD_INIT;
      integ_cnt <= '0;
      req_seen  <= 1'b0;
      pend      <= 1'b0;
      shadow    <= DEF_CFG;
      reg2tim_q <= DEF_CFG;
      tim_rst_q <= 1'b0;
      bus_on_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      if (!cfg_req_i) begin
        req_seen <= 1'b0;
      end else if (accept) begin
        req_seen <= 1'b1;
      end

      case (state)
        TC_HOLD: begin
          if (hold_cnt == '0) begin
            state     <= TC_INTEG;
            tim_rst_q <= 1'b1;
            integ_cnt <= '0;
            if (pend) begin
              ack_q <= 1'b1;
              pend  <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        TC_INTEG: begin
          if (accept && cfg_ok) begin
            shadow    <= cfg_in;
            reg2tim_q <= cfg_in;
            pend      <= 1'b1;
            state     <= TC_HOLD;
            hold_cnt  <= HOLD_INIT;
            tim_rst_q <= 1'b0;
          end else begin
            if (accept) begin
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end
            if (sample_point_i) begin
              if (!sampled_bit_i) begin
                integ_cnt <= '0;
              end else if (integ_cnt == INTEG_LAST) begin
                integ_cnt <= INTEG_MAX;
                state     <= TC_BUS_ON;
                bus_on_q  <= 1'b1;
              end else if (integ_cnt != INTEG_MAX) begin
                integ_cnt <= integ_cnt + 1'b1;
              end
            end
          end
        end

        TC_BUS_ON: begin
          if (accept && cfg_ok) begin
            shadow <= cfg_in;
            pend   <= 1'b1;
            state  <= TC_WAIT_IDLE;
          end else if (accept) begin
            ack_q <= 1'b1;
            err_q <= 1'b1;
          end
        end

        TC_WAIT_IDLE: begin
          if (rx_idle_i && !tx_busy_i) begin
            state     <= TC_HOLD;
            reg2tim_q <= shadow;
            hold_cnt  <= HOLD_INIT;
            bus_on_q  <= 1'b0;
            tim_rst_q <= 1'b0;
          end
        end

        default: state <= TC_HOLD;
      endcase
    end
  end

  assign cfg_ack_o   = ack_q;
  assign cfg_err_o   = err_q;
  assign reg2tim_o   = reg2tim_q;
  assign tim_rst_n_o = tim_rst_q & rst_n;
  assign bus_on_o    = bus_on_q;

endmodule

// File: tb/tb_can_timing_ctrl.sv
// Directed bench for can_timing_ctrl.
// Drives handshake/bus stimulus and checks outputs with immediate assertions.
module tb_can_timing_ctrl;
  import can_timing_ctrl_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          cfg_req_i;
  logic [5:0]    cfg_presc_i;
  logic [3:0]    cfg_tseg1_i;
  logic [2:0]    cfg_tseg2_i;
  logic [1:0]    cfg_sjw_i;
  logic          cfg_ack_o;
  logic          cfg_err_o;
  logic          rx_idle_i;
  logic          tx_busy_i;
  logic          sample_point_i;
  logic          sampled_bit_i;
  type_reg2tim_s reg2tim_o;
  logic          tim_rst_n_o;
  logic          bus_on_o;

  int total;
  int bad;

  can_timing_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_req_i      (cfg_req_i),
    .cfg_presc_i    (cfg_presc_i),
    .cfg_tseg1_i    (cfg_tseg1_i),
    .cfg_tseg2_i    (cfg_tseg2_i),
    .cfg_sjw_i      (cfg_sjw_i),
    .cfg_ack_o      (cfg_ack_o),
    .cfg_err_o      (cfg_err_o),
    .rx_idle_i      (rx_idle_i),
    .tx_busy_i      (tx_busy_i),
    .sample_point_i (sample_point_i),
    .sampled_bit_i  (sampled_bit_i),
    .reg2tim_o      (reg2tim_o),
    .tim_rst_n_o    (tim_rst_n_o),
    .bus_on_o       (bus_on_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rv(input logic [5:0] p,
                                     input logic [3:0] t1,
                                     input logic [2:0] t2,
                                     input logic [1:0] s);
    return {17'd0, p, t1, t2, s};
  endfunction

  task automatic sp(input logic b);
    sample_point_i = 1'b1;
    sampled_bit_i  = b;
    tick();
    sample_point_i = 1'b0;
    sampled_bit_i  = 1'b1;
  endtask

  task automatic integ11();
    for (int i = 0; i < 11; i++) sp(1'b1);
  endtask

  task automatic set_req(input logic [5:0] p, input logic [3:0] t1,
                         input logic [2:0] t2, input logic [1:0] s);
    cfg_presc_i = p;
    cfg_tseg1_i = t1;
    cfg_tseg2_i = t2;
    cfg_sjw_i   = s;
    cfg_req_i   = 1'b1;
  endtask

  int n;
  int acks;
  logic [31:0] r_first;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    cfg_req_i = 1'b0;
    cfg_presc_i = '0;
    cfg_tseg1_i = '0;
    cfg_tseg2_i = '0;
    cfg_sjw_i = '0;
    rx_idle_i = 1'b0;
    tx_busy_i = 1'b0;
    sample_point_i = 1'b0;
    sampled_bit_i = 1'b1;
    tick();
    tick();

    chk("rst_tim_rst", 32'(tim_rst_n_o), 32'd0);
    chk("rst_bus_on", 32'(bus_on_o), 32'd0);
    chk("rst_ack", 32'(cfg_ack_o), 32'd0);
    chk("rst_reg2tim", 32'(reg2tim_o), rv(6'd0, 4'd5, 3'd2, 3'd1));

    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tim_rst_n_o && n < 20);
    chk("hold_len", n, 4);

    for (int i = 0; i < 10; i++) sp(1'b1);
    chk("integ_10", 32'(bus_on_o), 32'd0);
    sp(1'b0);
    chk("integ_dom", 32'(bus_on_o), 32'd0);
    for (int i = 0; i < 10; i++) sp(1'b1);
    chk("integ_re10", 32'(bus_on_o), 32'd0);
    sp(1'b1);
    chk("integ_11", 32'(bus_on_o), 32'd1);

    // valid request while bus busy
    set_req(6'd3, 4'd8, 3'd3, 2'd2);
    tick();
    tick();
    tick();
    chk("busy_reg2tim", 32'(reg2tim_o), rv(6'd0, 4'd5, 3'd2, 2'd1));
    chk("busy_bus_on", 32'(bus_on_o), 32'd1);
    chk("busy_tim_rst", 32'(tim_rst_n_o), 32'd1);
    chk("busy_ack", 32'(cfg_ack_o), 32'd0);

    rx_idle_i = 1'b1;
    n = 0;
    r_first = '0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        r_first = 32'(reg2tim_o);
        chk("hold_bus_on", 32'(bus_on_o), 32'd0);
        chk("hold_tim_rst", 32'(tim_rst_n_o), 32'd0);
      end
    end while (!cfg_ack_o && n < 20);
    chk("apply_reg2tim", r_first, rv(6'd3, 4'd8, 3'd3, 2'd2));
    chk("ack_lat", n, 5);
    chk("ack_err", 32'(cfg_err_o), 32'd0);

    // req still high after ack: must not be re-accepted
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cfg_ack_o) acks++;
    end
    chk("held_no_reacc", acks, 0);
    chk("held_tim_rst", 32'(tim_rst_n_o), 32'd1);
    cfg_req_i = 1'b0;
    integ11();
    chk("reint_bus_on", 32'(bus_on_o), 32'd1);

    // invalid: sjw > tseg2
    set_req(6'd1, 4'd5, 3'd2, 2'd3);
    tick();
    chk("inv_ack", 32'(cfg_ack_o), 32'd1);
    chk("inv_err", 32'(cfg_err_o), 32'd1);
    chk("inv_reg2tim", 32'(reg2tim_o), rv(6'd3, 4'd8, 3'd3, 2'd2));
    chk("inv_bus_on", 32'(bus_on_o), 32'd1);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cfg_ack_o) acks++;
    end
    chk("inv_held", acks, 0);

    // drop one cycle, re-request with a valid set
    cfg_req_i = 1'b0;
    tick();
    set_req(6'd1, 4'd4, 3'd2, 2'd1);
    tick();
    tick();
    chk("reacc_reg2tim", 32'(reg2tim_o), rv(6'd1, 4'd4, 3'd2, 2'd1));
    chk("reacc_bus_on", 32'(bus_on_o), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cfg_ack_o && n < 20);
    chk("reacc_ack_lat", n, 4);
    cfg_req_i = 1'b0;

    // reset while waiting for idle
    integ11();
    chk("pre_rst_bus_on", 32'(bus_on_o), 32'd1);
    rx_idle_i = 1'b0;
    set_req(6'd2, 4'd6, 3'd2, 2'd1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_reg2tim", 32'(reg2tim_o), rv(6'd0, 4'd5, 3'd2, 2'd1));
    chk("abort_bus_on", 32'(bus_on_o), 32'd0);
    chk("abort_tim_rst", 32'(tim_rst_n_o), 32'd0);
    rst_n = 1'b1;
    cfg_req_i = 1'b0;
    rx_idle_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cfg_ack_o) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_tim_rel", 32'(tim_rst_n_o), 32'd1);
    chk("abort_def", 32'(reg2tim_o), rv(6'd0, 4'd5, 3'd2, 2'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
